wb_scheduler: RTL

// - Schedules the single register-file write port (reg_wr/address_wr/wb_out) among NREQ writeback producers (ALU, LSU, CSR).
// - Keeps a per-register pending scoreboard and stalls decode on RAW/WAW hazards against writes not yet committed.
// - Sits between the execute-side producers and the decode stage's register file.

---
 rtl/wb_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_scheduler.sv
// Writeback scheduler: arbitrates NREQ producers onto one register-file write port
// and keeps a pending-write scoreboard for decode hazards. WB_RR_EN selects round-robin.
module wb_scheduler #(
    parameter int width = 32,
    parameter int NREQ  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*5-1:0]       req_addr,
    input  logic [NREQ*width-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [4:0]              issue_rs1,
    input  logic [4:0]              issue_rs2,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    output logic                    stall,
    output logic                    reg_wr,
    output logic [4:0]              address_wr,
    output logic [width-1:0]        wb_out
);

    localparam int NREGS = 32;
    localparam int IW    = $clog2(NREQ);

    logic [NREGS-1:0]  pend_reg;
    logic              grant_any;
    logic [IW-1:0]     grant_idx;
    logic [4:0]        grant_addr;
    logic [width-1:0]  grant_data;
    logic              issue_set;

`ifdef WB_RR_EN
    logic [IW-1:0] rr_ptr_reg;

    // Search wraps around starting at the pointer; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else if (grant_any) begin
            rr_ptr_reg <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && (grant_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        grant_addr = '0;
        grant_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
                grant_addr = req_addr[5*k +: 5];
                grant_data = req_data[width*k +: width];
            end
        end
    end

    assign stall = issue_valid && ((rs1_used && pend_reg[issue_rs1]) ||
                                   (rs2_used && pend_reg[issue_rs2]) ||
                                   pend_reg[issue_rd]);

    assign issue_set = issue_valid && !stall && (issue_rd != 5'd0);

    // A same-cycle set beats the clear: the newly issued producer owns the register.
    // Bit 0 is never set because issue_set excludes rd==0.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pend_reg[gi] <= 1'b0;
                end else if (issue_set && (issue_rd == 5'(gi))) begin
                    pend_reg[gi] <= 1'b1;
                end else if (grant_any && (grant_addr == 5'(gi))) begin
                    pend_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_wr     <= 1'b0;
            address_wr <= '0;
            wb_out     <= '0;
        end else if (grant_any) begin
            reg_wr     <= (grant_addr != 5'd0);
            address_wr <= grant_addr;
            wb_out     <= grant_data;
        end else begin
            reg_wr     <= 1'b0;
        end
    end

endmodule
